// File: rtl/vball_sprite_buffer.sv
// vball_sprite_buffer: double-buffered sprite attribute RAM.
// CPU owns the working table; vblank copies it to the idle shadow bank.
module vball_sprite_buffer #(
  parameter int COPY_LEN = 256
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_din,
  input  logic       cpu_we,
  output logic [7:0] cpu_dout,
  input  logic       vblank,
  input  logic [7:0] sma,
  output logic [7:0] smd,
  output logic       busy,
  output logic       done,
  output logic       bank
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COPY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_SWAP  = 2'd3;

  localparam logic [7:0] LAST_ADDR = 8'(COPY_LEN - 1);

  logic [7:0] w_mem [0:255];
  logic [7:0] s_mem [0:511];

  logic [1:0] state_q, state_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       bank_q, bank_d;
  logic       vb_q, vb_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] w_rd_q;
  logic [7:0] smd_q;
  logic [7:0] cpu_dout_q;
  logic       vb_rise;

  assign vb_rise = vblank & ~vb_q;

  // Copy sequencer: issue reads, then flush the last write, then swap.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    bank_d    = bank_q;
    vb_d      = vblank;
    wr_en_d   = (state_q == ST_COPY);
    wr_addr_d = rd_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (vb_rise) begin
          state_d   = ST_COPY;
          rd_addr_d = '0;
        end
      end
      ST_COPY: begin
        if (!vblank) begin
          state_d = ST_IDLE;
        end else if (rd_addr_q == LAST_ADDR) begin
          state_d = ST_FLUSH;
        end else begin
          rd_addr_d = rd_addr_q + 8'd1;
        end
      end
      ST_FLUSH: begin
        state_d = vblank ? ST_SWAP : ST_IDLE;
      end
      ST_SWAP: begin
        bank_d  = ~bank_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      bank_q    <= 1'b0;
      vb_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      bank_q    <= bank_d;
      vb_q      <= vb_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Working RAM: CPU port A read-first, copy port B sees the old byte.
  always_ff @(posedge clk_sys) begin
    if (cpu_we) begin
      w_mem[cpu_addr] <= cpu_din;
    end
    w_rd_q <= w_mem[rd_addr_q];
  end

  // Shadow RAM write: only ever the bank not being displayed.
  always_ff @(posedge clk_sys) begin
    if (wr_en_q && !reset) begin
      s_mem[{~bank_q, wr_addr_q}] <= w_rd_q;
    end
  end

  // Registered read ports for the renderer and the CPU.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      smd_q      <= '0;
      cpu_dout_q <= '0;
    end else begin
      smd_q      <= s_mem[{bank_q, sma}];
      cpu_dout_q <= w_mem[cpu_addr];
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign smd      = smd_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_SWAP);
  assign bank     = bank_q;

endmodule

// File: tb/tb_vball_sprite_buffer.sv
// tb_vball_sprite_buffer: directed checks of copy, swap,
// abort, collision, edge filtering and reset mid-copy.
module tb_vball_sprite_buffer;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_din = '0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_dout;
  logic       vblank = 1'b0;
  logic [7:0] sma = '0;
  logic [7:0] smd;
  logic       busy;
  logic       done;
  logic       bank;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_rise = 0;
  logic busy_prev = 1'b0;

  vball_sprite_buffer #(.COPY_LEN(256)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cpu_addr(cpu_addr),
    .cpu_din (cpu_din),
    .cpu_we  (cpu_we),
    .cpu_dout(cpu_dout),
    .vblank  (vblank),
    .sma     (sma),
    .smd     (smd),
    .busy    (busy),
    .done    (done),
    .bank    (bank)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise++;
    busy_prev = busy;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic cpu_write(input logic [7:0] a,
                           input logic [7:0] d);
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    tick();
    cpu_we   = 1'b0;
  endtask

  // leaves the bench in cycle E+1 with cyc == 1
  task automatic start_frame();
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    cyc = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_busy got=%b exp=0", busy);
    end
    vec_cnt++;
    if (done !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_done got=%b exp=0", done);
    end
    vec_cnt++;
    if (bank !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_bank got=%b exp=0", bank);
    end
    vec_cnt++;
    if (smd !== 8'h00) begin
      err_cnt++;
      $display("FAIL rst_smd got=%h exp=00", smd);
    end
    vec_cnt++;
    if (cpu_dout !== 8'h00) begin
      err_cnt++;
      $display("FAIL rst_cpu_dout got=%h exp=00", cpu_dout);
    end
  endtask

  task automatic test_basic_copy();
    logic [7:0] exp;
    for (int i = 0; i < 256; i++) begin
      cpu_write(8'(i), 8'(i) ^ 8'hA5);
    end
    start_frame();
    for (int c = 1; c <= 258; c++) begin
      vec_cnt++;
      if (busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL basic_busy E+%0d got=%b exp=1", c, busy);
      end
      vec_cnt++;
      if (done !== (c == 258)) begin
        err_cnt++;
        $display("FAIL basic_done E+%0d got=%b exp=%b",
                 c, done, (c == 258));
      end
      tick();
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_busy_end got=%b exp=0", busy);
    end
    vec_cnt++;
    if (bank !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_bank got=%b exp=1", bank);
    end
    for (int i = 0; i < 256; i++) begin
      sma      = 8'(i);
      cpu_addr = 8'(i);
      tick();
      exp = 8'(i) ^ 8'hA5;
      vec_cnt++;
      if (smd !== exp) begin
        err_cnt++;
        $display("FAIL basic_smd[%0d] got=%h exp=%h", i, smd, exp);
      end
      vec_cnt++;
      if (cpu_dout !== exp) begin
        err_cnt++;
        $display("FAIL basic_cpu_dout[%0d] got=%h exp=%h",
                 i, cpu_dout, exp);
      end
    end
  endtask

  task automatic test_double_buffer();
    logic [7:0] exp;
    for (int i = 0; i < 256; i++) begin
      cpu_write(8'(i), ~8'(i));
    end
    start_frame();
    for (int j = 0; j <= 257; j++) begin
      vec_cnt++;
      if (done !== (j == 257)) begin
        err_cnt++;
        $display("FAIL dbl_done E+%0d got=%b exp=%b",
                 j + 1, done, (j == 257));
      end
      sma = 8'(j);
      tick();
      exp = 8'(j) ^ 8'hA5;
      vec_cnt++;
      if (smd !== exp) begin
        err_cnt++;
        $display("FAIL dbl_smd_old[%0d] got=%h exp=%h", j, smd, exp);
      end
    end
    vec_cnt++;
    if (bank !== 1'b0) begin
      err_cnt++;
      $display("FAIL dbl_bank got=%b exp=0", bank);
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL dbl_busy_end got=%b exp=0", busy);
    end
    for (int i = 0; i < 256; i++) begin
      sma = 8'(i);
      tick();
      exp = ~8'(i);
      vec_cnt++;
      if (smd !== exp) begin
        err_cnt++;
        $display("FAIL dbl_smd_new[%0d] got=%h exp=%h", i, smd, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    int d0;
    for (int i = 0; i < 256; i++) begin
      cpu_write(8'(i), 8'(i));
    end
    d0 = done_cnt;
    start_frame();
    for (int c = 1; c <= 100; c++) begin
      vec_cnt++;
      if (busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL abort_busy E+%0d got=%b exp=1", c, busy);
      end
      if (c == 100) vblank = 1'b0;
      tick();
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_busy_fall got=%b exp=0", busy);
    end
    for (int c = 0; c < 300; c++) tick();
    vec_cnt++;
    if (done_cnt != d0) begin
      err_cnt++;
      $display("FAIL abort_done got=%0d exp=%0d", done_cnt, d0);
    end
    vec_cnt++;
    if (bank !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_bank got=%b exp=0", bank);
    end
    for (int i = 0; i < 256; i++) begin
      sma = 8'(i);
      tick();
      exp = ~8'(i);
      vec_cnt++;
      if (smd !== exp) begin
        err_cnt++;
        $display("FAIL abort_smd[%0d] got=%h exp=%h", i, smd, exp);
      end
    end
  endtask

  task automatic test_collision();
    cpu_write(8'd50, 8'h11);
    start_frame();
    while (cyc < 51) tick();
    cpu_we   = 1'b1;
    cpu_addr = 8'd50;
    cpu_din  = 8'h3C;
    tick();
    cpu_we = 1'b0;
    tick();
    vec_cnt++;
    if (cpu_dout !== 8'h3C) begin
      err_cnt++;
      $display("FAIL coll_cpu_dout got=%h exp=3c", cpu_dout);
    end
    while (cyc < 259) tick();
    vec_cnt++;
    if (bank !== 1'b1) begin
      err_cnt++;
      $display("FAIL coll_bank1 got=%b exp=1", bank);
    end
    sma = 8'd50;
    tick();
    vec_cnt++;
    if (smd !== 8'h11) begin
      err_cnt++;
      $display("FAIL coll_s50_old got=%h exp=11", smd);
    end
    sma = 8'd49;
    tick();
    vec_cnt++;
    if (smd !== 8'd49) begin
      err_cnt++;
      $display("FAIL coll_s49 got=%h exp=31", smd);
    end
    start_frame();
    while (cyc < 259) tick();
    vec_cnt++;
    if (bank !== 1'b0) begin
      err_cnt++;
      $display("FAIL coll_bank0 got=%b exp=0", bank);
    end
    sma = 8'd50;
    tick();
    vec_cnt++;
    if (smd !== 8'h3C) begin
      err_cnt++;
      $display("FAIL coll_s50_new got=%h exp=3c", smd);
    end
    sma = 8'd51;
    tick();
    vec_cnt++;
    if (smd !== 8'd51) begin
      err_cnt++;
      $display("FAIL coll_s51 got=%h exp=33", smd);
    end
  endtask

  task automatic test_edge_filter();
    int d0;
    int r0;
    d0 = done_cnt;
    r0 = busy_rise;
    start_frame();
    while (cyc < 10000) tick();
    vec_cnt++;
    if (done_cnt - d0 != 1) begin
      err_cnt++;
      $display("FAIL edge_done_count got=%0d exp=1", done_cnt - d0);
    end
    vec_cnt++;
    if (busy_rise - r0 != 1) begin
      err_cnt++;
      $display("FAIL edge_copy_count got=%0d exp=1", busy_rise - r0);
    end
    vec_cnt++;
    if (bank !== 1'b1) begin
      err_cnt++;
      $display("FAIL edge_bank got=%b exp=1", bank);
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL edge_busy_idle got=%b exp=0", busy);
    end
    start_frame();
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL edge_rearm got=%b exp=1", busy);
    end
  endtask

  // continues the copy started at the end of test_edge_filter
  task automatic test_reset_mid_copy();
    int d0;
    while (cyc < 30) tick();
    d0 = done_cnt;
    reset  = 1'b1;
    vblank = 1'b0;
    tick();
    reset = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rmc_busy got=%b exp=0", busy);
    end
    vec_cnt++;
    if (bank !== 1'b0) begin
      err_cnt++;
      $display("FAIL rmc_bank got=%b exp=0", bank);
    end
    vec_cnt++;
    if (smd !== 8'h00) begin
      err_cnt++;
      $display("FAIL rmc_smd got=%h exp=00", smd);
    end
    vec_cnt++;
    if (done !== 1'b0) begin
      err_cnt++;
      $display("FAIL rmc_done got=%b exp=0", done);
    end
    for (int c = 0; c < 300; c++) tick();
    vec_cnt++;
    if (done_cnt != d0) begin
      err_cnt++;
      $display("FAIL rmc_done_count got=%0d exp=%0d", done_cnt, d0);
    end
    vec_cnt++;
    if (bank !== 1'b0) begin
      err_cnt++;
      $display("FAIL rmc_bank_hold got=%b exp=0", bank);
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_double_buffer();
    test_abort();
    test_collision();
    test_edge_filter();
    test_reset_mid_copy();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
